probe_fanout_unit: RTL



---
 rtl/probe_fanout_unit_pkg.sv | 26 ++
 rtl/probe_fanout_unit_if.sv | 62 ++++++
 rtl/probe_fanout_unit_prio_enc.sv | 22 ++
 rtl/probe_fanout_unit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/probe_fanout_unit_pkg.sv
// Shared definitions for the probe fan-out unit: state encoding, field
// widths and the default hub identifier placed in every probe header.
package probe_fanout_unit_pkg;

    localparam int N_CLIENTS    = 4;
    localparam int ADDR_BLOCK_W = 26;
    localparam int P_TYPE_W     = 2;
    localparam int CLIENT_ID_W  = 2;

    localparam logic [CLIENT_ID_W-1:0] HUB_ID_DEFAULT = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } fanout_state_t;

    // One-hot client mask for a client index.
    function automatic logic [N_CLIENTS-1:0] client_onehot(input logic [CLIENT_ID_W-1:0] id);
        logic [N_CLIENTS-1:0] result;
        result     = '0;
        result[id] = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/probe_fanout_unit_if.sv
// Bundle of the request, probe, acknowledge and status signals of the probe
// fan-out unit. The slave modport is the unit's view; master is its environment.
interface probe_fanout_unit_if
    import probe_fanout_unit_pkg::*;
();

    logic                    io_req_ready;
    logic                    io_req_valid;
    logic [ADDR_BLOCK_W-1:0] io_req_addr_block;
    logic [P_TYPE_W-1:0]     io_req_p_type;
    logic [N_CLIENTS-1:0]    io_req_client_mask;

    logic                    io_probe_ready;
    logic                    io_probe_valid;
    logic [CLIENT_ID_W-1:0]  io_probe_bits_header_src;
    logic [CLIENT_ID_W-1:0]  io_probe_bits_header_dst;
    logic [ADDR_BLOCK_W-1:0] io_probe_bits_payload_addr_block;
    logic [P_TYPE_W-1:0]     io_probe_bits_payload_p_type;

    logic                    io_ack_valid;
    logic [CLIENT_ID_W-1:0]  io_ack_client;

    logic                    io_busy;
    logic                    io_done;

    modport slave (
        output io_req_ready,
        input  io_req_valid,
        input  io_req_addr_block,
        input  io_req_p_type,
        input  io_req_client_mask,
        input  io_probe_ready,
        output io_probe_valid,
        output io_probe_bits_header_src,
        output io_probe_bits_header_dst,
        output io_probe_bits_payload_addr_block,
        output io_probe_bits_payload_p_type,
        input  io_ack_valid,
        input  io_ack_client,
        output io_busy,
        output io_done
    );

    modport master (
        input  io_req_ready,
        output io_req_valid,
        output io_req_addr_block,
        output io_req_p_type,
        output io_req_client_mask,
        output io_probe_ready,
        input  io_probe_valid,
        input  io_probe_bits_header_src,
        input  io_probe_bits_header_dst,
        input  io_probe_bits_payload_addr_block,
        input  io_probe_bits_payload_p_type,
        output io_ack_valid,
        output io_ack_client,
        input  io_busy,
        input  io_done
    );

endinterface

// File: rtl/probe_fanout_unit_prio_enc.sv
// Lowest-set-bit priority encoder over the client mask; picks which client
// gets the next probe.
module probe_client_prio_enc
    import probe_fanout_unit_pkg::*;
(
    input  logic [N_CLIENTS-1:0]   mask,
    output logic [CLIENT_ID_W-1:0] index,
    output logic                   any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        any   = |mask;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = CLIENT_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/probe_fanout_unit.sv
// Probe fan-out unit: takes one probe request, emits one probe per selected
// client (lowest index first) and pulses done once every probed client acked.
module probe_fanout_unit
    import probe_fanout_unit_pkg::*;
#(
    parameter logic [CLIENT_ID_W-1:0] HUB_ID = HUB_ID_DEFAULT
)
(
    input  logic                clk,
    input  logic                reset,
    probe_fanout_unit_if.slave  bus
);

    fanout_state_t           state;
    fanout_state_t           state_next;
    logic [N_CLIENTS-1:0]    to_send;
    logic [N_CLIENTS-1:0]    to_send_next;
    logic [N_CLIENTS-1:0]    wait_ack;
    logic [N_CLIENTS-1:0]    wait_ack_next;
    logic [ADDR_BLOCK_W-1:0] addr_q;
    logic [ADDR_BLOCK_W-1:0] addr_next;
    logic [P_TYPE_W-1:0]     p_type_q;
    logic [P_TYPE_W-1:0]     p_type_next;

    logic [CLIENT_ID_W-1:0]  send_dst;
    logic                    send_any;
    logic [N_CLIENTS-1:0]    ack_clear;
    logic                    probe_fire;
    logic                    req_ready;
    logic                    probe_valid;
    logic                    busy;
    logic                    done;

    probe_client_prio_enc u_prio_enc (
        .mask  (to_send),
        .index (send_dst),
        .any   (send_any)
    );

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            to_send  <= '0;
            wait_ack <= '0;
            addr_q   <= '0;
            p_type_q <= '0;
        end else begin
            state    <= state_next;
            to_send  <= to_send_next;
            wait_ack <= wait_ack_next;
            addr_q   <= addr_next;
            p_type_q <= p_type_next;
        end
    end

    // Next-state, probe issue and ack bookkeeping; an ack only counts for a
    // client whose probe has already gone out in an earlier cycle.
    always_comb begin
        state_next    = state;
        to_send_next  = to_send;
        wait_ack_next = wait_ack;
        addr_next     = addr_q;
        p_type_next   = p_type_q;
        req_ready     = 1'b0;
        probe_valid   = 1'b0;
        probe_fire    = 1'b0;
        ack_clear     = '0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (bus.io_req_valid) begin
                    addr_next     = bus.io_req_addr_block;
                    p_type_next   = bus.io_req_p_type;
                    to_send_next  = bus.io_req_client_mask;
                    wait_ack_next = bus.io_req_client_mask;
                    if (bus.io_req_client_mask != '0) begin
                        state_next = ST_SEND;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_SEND: begin
                probe_valid = send_any;
                probe_fire  = send_any && bus.io_probe_ready;
                if (bus.io_ack_valid && wait_ack[bus.io_ack_client]
                    && !to_send[bus.io_ack_client]) begin
                    ack_clear = client_onehot(bus.io_ack_client);
                end
                if (probe_fire) begin
                    to_send_next = to_send & ~client_onehot(send_dst);
                end
                wait_ack_next = wait_ack & ~ack_clear;
                if (to_send_next == '0 && wait_ack_next == '0) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.io_req_ready                     = req_ready;
    assign bus.io_probe_valid                   = probe_valid;
    assign bus.io_probe_bits_header_src         = HUB_ID;
    assign bus.io_probe_bits_header_dst         = send_dst;
    assign bus.io_probe_bits_payload_addr_block = addr_q;
    assign bus.io_probe_bits_payload_p_type     = p_type_q;
    assign bus.io_busy                          = busy;
    assign bus.io_done                          = done;

endmodule
